// File: rtl/rv_emu_retire_cmp_pkg.sv
// Shared types for the retire comparator: retire record, check mask, instruction
// type and comparator state, plus the masked field compare used on every retire.
package rv_emu_retire_cmp_pkg;

  typedef enum logic [5:0] {
    _OTHER_ = 6'd0,
    _ADDI_  = 6'd1,
    _ADD_   = 6'd2,
    _LW_    = 6'd3,
    _SW_    = 6'd4,
    _BEQ_   = 6'd5,
    _JAL_   = 6'd6,
    _CSRRW_ = 6'd7,
    _ECALL_ = 6'd8
  } INSTR_TYPE;

  // First member is the MSB: pc is bit 0, events is bit 15.
  typedef struct packed {
    logic events;
    logic csr_rd_data;
    logic csr_rd;
    logic rs2_data;
    logic rs2_addr;
    logic rs1_data;
    logic rs1_addr;
    logic mode;
    logic exc;
    logic csr_wr_data;
    logic csr_addr;
    logic csr_wr;
    logic gpr_data;
    logic gpr_addr;
    logic gpr_wr;
    logic pc;
  } CHECKS;

  typedef struct packed {
    logic [31:0] pc;
    INSTR_TYPE   itype;
    logic        gpr_wr;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;
    logic        csr_wr;
    logic [11:0] csr_addr;
    logic [31:0] csr_wr_data;
    logic        exc;
    logic [5:0]  cause;
    logic [31:0] tval;
    logic [1:0]  mode;
    CHECKS       chk;
  } RET_REC_T;

  typedef enum logic {
    CMP_RUN  = 1'b0,
    CMP_FAIL = 1'b1
  } CMP_STATE_T;

  // Returns the set of checked fields that differ; register-read and event
  // bits always come back 0 because this block never observes them.
  function automatic CHECKS chk_compare(input RET_REC_T exp, input RET_REC_T act);
    CHECKS m;
    m             = '0;
    m.pc          = exp.chk.pc && (exp.pc != act.pc);
    m.gpr_wr      = exp.chk.gpr_wr && (exp.gpr_wr != act.gpr_wr);
    m.gpr_addr    = exp.chk.gpr_addr && exp.gpr_wr && (exp.gpr_addr != act.gpr_addr);
    m.gpr_data    = exp.chk.gpr_data && exp.gpr_wr && (exp.gpr_data != act.gpr_data);
    m.csr_wr      = exp.chk.csr_wr && (exp.csr_wr != act.csr_wr);
    m.csr_addr    = exp.chk.csr_addr && exp.csr_wr && (exp.csr_addr != act.csr_addr);
    m.csr_wr_data = exp.chk.csr_wr_data && exp.csr_wr && (exp.csr_wr_data != act.csr_wr_data);
    m.exc         = exp.chk.exc && ((exp.exc != act.exc) ||
                    (exp.exc && ((exp.cause != act.cause) || (exp.tval != act.tval))));
    m.mode        = exp.chk.mode && (exp.mode != act.mode);
    return m;
  endfunction

endpackage

// File: rtl/rv_emu_retire_cmp_rec_fifo.sv
// Synchronous FIFO of retire records; pointers carry a wrap bit so full and
// empty fall out of a plain pointer compare.
module rv_emu_rec_fifo
  import rv_emu_retire_cmp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  RET_REC_T wdata,
  output RET_REC_T rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  RET_REC_T    mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv_emu_retire_cmp.sv
// In-order checker of CPU retire events against emulator-predicted records,
// with masked per-field compare, sticky underflow/timeout errors and counters.
module rv_emu_retire_cmp
  import rv_emu_retire_cmp_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 1024,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        emu_valid_in,
  output logic        emu_ready_out,
  input  RET_REC_T    emu_rec_in,
  input  logic        cpu_valid_in,
  input  RET_REC_T    cpu_rec_in,
  input  logic        clear_in,
  output logic        mismatch_out,
  output CHECKS       mismatch_flds_out,
  output INSTR_TYPE   mismatch_itype_out,
  output logic        err_underflow_out,
  output logic        err_timeout_out,
  output logic        fail_out,
  output logic [31:0] retire_cnt_out,
  output logic [15:0] mismatch_cnt_out
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TIMEOUT_W = WD_W'(TIMEOUT);

  // Handshakes: an emulator record transfers on any cycle with
  // emu_valid_in && emu_ready_out; the CPU side has no backpressure and
  // cpu_valid_in is a single-cycle retire strobe consumed (or flagged) at once.

  CMP_STATE_T       state_q, state_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             err_underflow_q, err_underflow_d;
  logic             err_timeout_q, err_timeout_d;
  logic             mismatch_q, mismatch_d;
  CHECKS            mismatch_flds_q, mismatch_flds_d;
  INSTR_TYPE        mismatch_itype_q, mismatch_itype_d;
  logic [31:0]      retire_cnt_q, retire_cnt_d;
  logic [15:0]      mismatch_cnt_q, mismatch_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  RET_REC_T         head;
  logic             push;
  logic             pop;
  CHECKS            flds;
  logic             cmp_bad;
  logic             underflow_evt;
  logic             timeout_evt;

  assign push          = emu_valid_in && !fifo_full;
  assign pop           = cpu_valid_in && !fifo_empty && (state_q == CMP_RUN);
  assign underflow_evt = cpu_valid_in && fifo_empty && (state_q == CMP_RUN);
  assign flds          = chk_compare(head, cpu_rec_in);
  assign cmp_bad       = pop && (flds != '0);

  rv_emu_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .clear (clear_in),
    .push  (push),
    .pop   (pop),
    .wdata (emu_rec_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d          = state_q;
    wdog_d           = wdog_q;
    err_underflow_d  = err_underflow_q;
    err_timeout_d    = err_timeout_q;
    mismatch_d       = 1'b0;
    mismatch_flds_d  = '0;
    mismatch_itype_d = _OTHER_;
    retire_cnt_d     = retire_cnt_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    timeout_evt      = 1'b0;
    if (clear_in) begin
      state_d         = CMP_RUN;
      wdog_d          = '0;
      err_underflow_d = 1'b0;
      err_timeout_d   = 1'b0;
      retire_cnt_d    = '0;
      mismatch_cnt_d  = '0;
    end else begin
      if (pop) begin
        retire_cnt_d = retire_cnt_q + 32'd1;
      end
      if (cmp_bad) begin
        mismatch_d       = 1'b1;
        mismatch_flds_d  = flds;
        mismatch_itype_d = head.itype;
        if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
      end
      // The watchdog only measures stalls while the checker is actively comparing.
      if (fifo_empty || pop || (state_q != CMP_RUN)) begin
        wdog_d = '0;
      end else if (wdog_q != TIMEOUT_W) begin
        wdog_d = wdog_q + 1'b1;
      end
      timeout_evt = (state_q == CMP_RUN) && (wdog_d == TIMEOUT_W);
      if (underflow_evt) err_underflow_d = 1'b1;
      if (timeout_evt)   err_timeout_d   = 1'b1;
      if (STOP_ON_ERR && (state_q == CMP_RUN) && (cmp_bad || underflow_evt || timeout_evt)) begin
        state_d = CMP_FAIL;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q          <= CMP_RUN;
      wdog_q           <= '0;
      err_underflow_q  <= 1'b0;
      err_timeout_q    <= 1'b0;
      mismatch_q       <= 1'b0;
      mismatch_flds_q  <= '0;
      mismatch_itype_q <= _OTHER_;
      retire_cnt_q     <= '0;
      mismatch_cnt_q   <= '0;
    end else begin
      state_q          <= state_d;
      wdog_q           <= wdog_d;
      err_underflow_q  <= err_underflow_d;
      err_timeout_q    <= err_timeout_d;
      mismatch_q       <= mismatch_d;
      mismatch_flds_q  <= mismatch_flds_d;
      mismatch_itype_q <= mismatch_itype_d;
      retire_cnt_q     <= retire_cnt_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
    end
  end

  assign emu_ready_out      = !fifo_full;
  assign mismatch_out       = mismatch_q;
  assign mismatch_flds_out  = mismatch_flds_q;
  assign mismatch_itype_out = mismatch_itype_q;
  assign err_underflow_out  = err_underflow_q;
  assign err_timeout_out    = err_timeout_q;
  assign fail_out           = (state_q == CMP_FAIL);
  assign retire_cnt_out     = retire_cnt_q;
  assign mismatch_cnt_out   = mismatch_cnt_q;

endmodule

// File: tb/tb_rv_emu_retire_cmp.sv
// Bench for rv_emu_retire_cmp: compare-rule vector table, directed multi-cycle
// sequences, then random traffic checked against a queue-based reference model.
module tb_rv_emu_retire_cmp;
  import rv_emu_retire_cmp_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam bit STOP_ON_ERR = 1'b1;
  localparam int REC_W   = $bits(RET_REC_T);

  logic        clk_in;
  logic        reset_n_in;
  logic        emu_valid_in;
  logic        emu_ready_out;
  RET_REC_T    emu_rec_in;
  logic        cpu_valid_in;
  RET_REC_T    cpu_rec_in;
  logic        clear_in;
  logic        mismatch_out;
  CHECKS       mismatch_flds_out;
  INSTR_TYPE   mismatch_itype_out;
  logic        err_underflow_out;
  logic        err_timeout_out;
  logic        fail_out;
  logic [31:0] retire_cnt_out;
  logic [15:0] mismatch_cnt_out;

  rv_emu_retire_cmp #(
    .DEPTH       (DEPTH),
    .TIMEOUT     (TIMEOUT),
    .STOP_ON_ERR (STOP_ON_ERR)
  ) dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .emu_valid_in       (emu_valid_in),
    .emu_ready_out      (emu_ready_out),
    .emu_rec_in         (emu_rec_in),
    .cpu_valid_in       (cpu_valid_in),
    .cpu_rec_in         (cpu_rec_in),
    .clear_in           (clear_in),
    .mismatch_out       (mismatch_out),
    .mismatch_flds_out  (mismatch_flds_out),
    .mismatch_itype_out (mismatch_itype_out),
    .err_underflow_out  (err_underflow_out),
    .err_timeout_out    (err_timeout_out),
    .fail_out           (fail_out),
    .retire_cnt_out     (retire_cnt_out),
    .mismatch_cnt_out   (mismatch_cnt_out)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int errors = 0;
  int checks = 0;

  logic [REC_W-1:0] exp_q[$];
  logic        m_fail;
  logic        m_uf;
  logic        m_to;
  int          m_idle;
  logic [31:0] m_ret;
  int          m_mcnt;
  logic        m_mm;
  logic [15:0] m_flds;
  INSTR_TYPE   m_itype;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Field index f of the check mask: which fields differ given the gating rules.
  function automatic logic [15:0] model_flds(input RET_REC_T e, input RET_REC_T a);
    logic [15:0] m;
    logic [15:0] c;
    logic        d;
    m = '0;
    c = e.chk;
    for (int f = 0; f < 9; f++) begin
      case (f)
        0: d = (e.pc != a.pc);
        1: d = (e.gpr_wr != a.gpr_wr);
        2: d = e.gpr_wr && (e.gpr_addr != a.gpr_addr);
        3: d = e.gpr_wr && (e.gpr_data != a.gpr_data);
        4: d = (e.csr_wr != a.csr_wr);
        5: d = e.csr_wr && (e.csr_addr != a.csr_addr);
        6: d = e.csr_wr && (e.csr_wr_data != a.csr_wr_data);
        7: d = (e.exc != a.exc) || (e.exc && ((e.cause != a.cause) || (e.tval != a.tval)));
        default: d = (e.mode != a.mode);
      endcase
      m[f] = c[f] && d;
    end
    return m;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_fail = 1'b0; m_uf = 1'b0; m_to = 1'b0; m_idle = 0;
    m_ret = '0; m_mcnt = 0; m_mm = 1'b0; m_flds = '0; m_itype = _OTHER_;
  endtask

  task automatic model_step(input logic clr, input logic ev, input logic cv,
                            input RET_REC_T er, input RET_REC_T ea);
    logic full, empty, pop, uf, to;
    RET_REC_T hd;
    logic [15:0] f;
    m_mm = 1'b0; m_flds = '0; m_itype = _OTHER_;
    if (clr) begin
      model_reset();
      return;
    end
    full  = (exp_q.size() == DEPTH);
    empty = (exp_q.size() == 0);
    pop   = cv && !empty && !m_fail;
    uf    = cv && empty && !m_fail;
    if (pop) begin
      hd = RET_REC_T'(exp_q.pop_front());
      f  = model_flds(hd, ea);
      m_ret = m_ret + 32'd1;
      if (f != 0) begin
        m_mm = 1'b1; m_flds = f; m_itype = hd.itype;
        if (m_mcnt < 65535) m_mcnt++;
      end
    end
    if (empty || pop || m_fail) m_idle = 0;
    else if (m_idle < TIMEOUT) m_idle++;
    to = (m_idle == TIMEOUT) && !m_fail;
    if (uf) m_uf = 1'b1;
    if (to) m_to = 1'b1;
    if (!m_fail && STOP_ON_ERR && (m_mm || uf || to)) m_fail = 1'b1;
    if (ev && !full) exp_q.push_back(er);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    cyc();
    clear_in = 1'b0;
  endtask

  task automatic push(input RET_REC_T r);
    emu_valid_in = 1'b1;
    emu_rec_in   = r;
    cyc();
    emu_valid_in = 1'b0;
  endtask

  task automatic retire(input RET_REC_T a);
    cpu_valid_in = 1'b1;
    cpu_rec_in   = a;
    cyc();
    cpu_valid_in = 1'b0;
  endtask

  function automatic RET_REC_T base_rec(input logic [31:0] pc);
    RET_REC_T r;
    r             = '0;
    r.pc          = pc;
    r.itype       = _ADDI_;
    r.gpr_wr      = 1'b1;
    r.gpr_addr    = 5'd5;
    r.gpr_data    = 32'd7;
    r.csr_addr    = 12'h300;
    r.csr_wr_data = 32'h8;
    r.mode        = 2'b11;
    r.chk         = CHECKS'(16'h000F);
    return r;
  endfunction

  function automatic RET_REC_T rand_rec();
    RET_REC_T r;
    r.pc          = $urandom;
    r.itype       = INSTR_TYPE'(6'($urandom_range(0, 8)));
    r.gpr_wr      = 1'($urandom_range(0, 1));
    r.gpr_addr    = 5'($urandom);
    r.gpr_data    = $urandom;
    r.csr_wr      = 1'($urandom_range(0, 1));
    r.csr_addr    = 12'($urandom);
    r.csr_wr_data = $urandom;
    r.exc         = 1'($urandom_range(0, 1));
    r.cause       = 6'($urandom);
    r.tval        = $urandom;
    r.mode        = 2'($urandom);
    r.chk         = CHECKS'(16'($urandom));
    return r;
  endfunction

  function automatic RET_REC_T corrupt(input RET_REC_T r, input int k);
    RET_REC_T a;
    a = r;
    case (k)
      1:  a.pc          = r.pc ^ 32'h4;
      2:  a.gpr_wr      = ~r.gpr_wr;
      3:  a.gpr_addr    = r.gpr_addr ^ 5'h1;
      4:  a.gpr_data    = r.gpr_data ^ 32'h1;
      5:  a.csr_wr      = ~r.csr_wr;
      6:  a.csr_addr    = r.csr_addr ^ 12'h1;
      7:  a.csr_wr_data = r.csr_wr_data ^ 32'h1;
      8:  a.exc         = ~r.exc;
      9:  a.cause       = r.cause ^ 6'h1;
      10: a.tval        = r.tval ^ 32'h1;
      11: a.mode        = r.mode ^ 2'b01;
      12: a.itype       = (r.itype == _ADD_) ? _ADDI_ : _ADD_;
      default: a = r;
    endcase
    return a;
  endfunction

  // ---------------- compare-rule vector table ----------------
  typedef struct {
    logic [15:0] chk;
    logic        e_gwr;
    logic        e_cwr;
    logic        e_exc;
    int          corrupt_k;
    logic [15:0] flds;
  } vec_t;

  vec_t vecs[18];

  initial begin
    RET_REC_T r, a;
    RET_REC_T recs[9];
    int cpu_prob;
    logic clr, ev, cv;

    vecs[0]  = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 0,  16'h0000};
    vecs[1]  = '{16'h0001, 1'b1, 1'b0, 1'b0, 1,  16'h0001};
    vecs[2]  = '{16'hFFF7, 1'b1, 1'b0, 1'b0, 4,  16'h0000};
    vecs[3]  = '{16'h0004, 1'b0, 1'b0, 1'b0, 3,  16'h0000};
    vecs[4]  = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 4,  16'h0008};
    vecs[5]  = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 6,  16'h0020};
    vecs[6]  = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 7,  16'h0000};
    vecs[7]  = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 9,  16'h0080};
    vecs[8]  = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 10, 16'h0000};
    vecs[9]  = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 11, 16'h0100};
    vecs[10] = '{16'hFEFF, 1'b1, 1'b0, 1'b0, 11, 16'h0000};
    vecs[11] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 12, 16'h0000};
    vecs[12] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 2,  16'h0002};
    vecs[13] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 5,  16'h0010};
    vecs[14] = '{16'hFE00, 1'b1, 1'b0, 1'b0, 1,  16'h0000};
    vecs[15] = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 7,  16'h0040};
    vecs[16] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 8,  16'h0080};
    vecs[17] = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 1,  16'h0001};

    reset_n_in   = 1'b0;
    emu_valid_in = 1'b0;
    cpu_valid_in = 1'b0;
    clear_in     = 1'b0;
    emu_rec_in   = '0;
    cpu_rec_in   = '0;
    repeat (3) cyc();
    reset_n_in = 1'b1;
    cyc();

    // Reset state
    check("rst_ready", 32'(emu_ready_out), 32'd1);
    check("rst_mismatch", 32'(mismatch_out), 32'd0);
    check("rst_underflow", 32'(err_underflow_out), 32'd0);
    check("rst_timeout", 32'(err_timeout_out), 32'd0);
    check("rst_fail", 32'(fail_out), 32'd0);
    check("rst_retire_cnt", retire_cnt_out, 32'd0);
    check("rst_mismatch_cnt", 32'(mismatch_cnt_out), 32'd0);

    // Three matching ADDI retires
    for (int k = 0; k < 3; k++) push(base_rec(32'h100 + 32'(k * 4)));
    for (int k = 0; k < 3; k++) begin
      retire(base_rec(32'h100 + 32'(k * 4)));
      check("t1_mismatch", 32'(mismatch_out), 32'd0);
    end
    check("t1_retire_cnt", retire_cnt_out, 32'd3);
    check("t1_fail", 32'(fail_out), 32'd0);

    // GPR data mismatch, 7 expected vs 8 retired
    do_clear();
    r = base_rec(32'h100);
    a = r;
    a.gpr_data = 32'd8;
    push(r);
    retire(a);
    check("t2_mismatch", 32'(mismatch_out), 32'd1);
    check("t2_flds", 32'(mismatch_flds_out), 32'h0008);
    check("t2_itype", 32'(mismatch_itype_out), 32'(_ADDI_));
    check("t2_fail", 32'(fail_out), 32'd1);
    check("t2_mismatch_cnt", 32'(mismatch_cnt_out), 32'd1);
    cyc();
    check("t2_pulse_end", 32'(mismatch_out), 32'd0);
    check("t2_fail_hold", 32'(fail_out), 32'd1);

    // Vector table of compare rules
    for (int i = 0; i < 18; i++) begin
      do_clear();
      r        = base_rec(32'h200 + 32'(i * 4));
      r.chk    = CHECKS'(vecs[i].chk);
      r.gpr_wr = vecs[i].e_gwr;
      r.csr_wr = vecs[i].e_cwr;
      r.exc    = vecs[i].e_exc;
      if (vecs[i].e_exc) begin
        r.cause = 6'd2;
        r.tval  = 32'hDEAD;
      end
      a     = corrupt(r, vecs[i].corrupt_k);
      a.chk = CHECKS'(16'($urandom));
      push(r);
      retire(a);
      check($sformatf("vec%0d_mismatch", i), 32'(mismatch_out), 32'(vecs[i].flds != 16'h0));
      if (vecs[i].flds != 16'h0) check($sformatf("vec%0d_flds", i), 32'(mismatch_flds_out), 32'(vecs[i].flds));
      check($sformatf("vec%0d_fail", i), 32'(fail_out), 32'(vecs[i].flds != 16'h0));
      check($sformatf("vec%0d_retire_cnt", i), retire_cnt_out, 32'd1);
    end

    // Underflow with a simultaneous push; the push must still land
    do_clear();
    emu_valid_in = 1'b1;
    emu_rec_in   = base_rec(32'h300);
    cpu_valid_in = 1'b1;
    cpu_rec_in   = base_rec(32'h300);
    cyc();
    cpu_valid_in = 1'b0;
    check("t4_underflow", 32'(err_underflow_out), 32'd1);
    check("t4_fail", 32'(fail_out), 32'd1);
    check("t4_retire_cnt", retire_cnt_out, 32'd0);
    check("t4_mismatch", 32'(mismatch_out), 32'd0);
    for (int k = 1; k < 8; k++) begin
      emu_rec_in = base_rec(32'h300 + 32'(k * 4));
      cyc();
      check($sformatf("t4_ready_%0d", k), 32'(emu_ready_out), 32'(k < 7));
    end
    emu_valid_in = 1'b0;

    // Fill, retire while full with push refused, then 9th push accepted
    do_clear();
    for (int k = 0; k < 9; k++) begin
      recs[k]          = base_rec(32'h400 + 32'(k * 4));
      recs[k].gpr_data = 32'(k);
      recs[k].chk      = CHECKS'(16'hFFFF);
    end
    emu_valid_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      emu_rec_in = recs[k];
      cyc();
      check($sformatf("t5_ready_%0d", k), 32'(emu_ready_out), 32'(k < 7));
    end
    emu_rec_in   = recs[8];
    cpu_valid_in = 1'b1;
    cpu_rec_in   = recs[0];
    cyc();
    cpu_valid_in = 1'b0;
    check("t5_ready_after_pop", 32'(emu_ready_out), 32'd1);
    check("t5_pop_mismatch", 32'(mismatch_out), 32'd0);
    cyc();
    emu_valid_in = 1'b0;
    check("t5_ready_9th", 32'(emu_ready_out), 32'd0);
    for (int k = 1; k < 9; k++) begin
      retire(recs[k]);
      check($sformatf("t5_order_%0d", k), 32'(mismatch_out), 32'd0);
    end
    check("t5_retire_cnt", retire_cnt_out, 32'd9);
    check("t5_fail", 32'(fail_out), 32'd0);
    retire(recs[0]);
    check("t5_drained", 32'(err_underflow_out), 32'd1);

    // Watchdog: one record, no retires
    do_clear();
    push(base_rec(32'h500));
    for (int t = 1; t <= 16; t++) begin
      cyc();
      if (t == 15) check("t6_timeout_early", 32'(err_timeout_out), 32'd0);
      if (t == 16) begin
        check("t6_timeout", 32'(err_timeout_out), 32'd1);
        check("t6_fail", 32'(fail_out), 32'd1);
      end
    end
    do_clear();
    check("t6_clr_timeout", 32'(err_timeout_out), 32'd0);
    check("t6_clr_underflow", 32'(err_underflow_out), 32'd0);
    check("t6_clr_fail", 32'(fail_out), 32'd0);
    check("t6_clr_ready", 32'(emu_ready_out), 32'd1);
    check("t6_clr_retire_cnt", retire_cnt_out, 32'd0);
    check("t6_clr_mismatch_cnt", 32'(mismatch_cnt_out), 32'd0);
    retire(base_rec(32'h500));
    check("t6_clr_empty", 32'(err_underflow_out), 32'd1);

    // Asynchronous reset mid-stream discards queued records
    do_clear();
    push(base_rec(32'h600));
    push(base_rec(32'h604));
    reset_n_in = 1'b0;
    #2;
    reset_n_in = 1'b1;
    check("arst_retire_cnt", retire_cnt_out, 32'd0);
    check("arst_fail", 32'(fail_out), 32'd0);
    retire(base_rec(32'h600));
    check("arst_empty", 32'(err_underflow_out), 32'd1);

    // Random traffic against the reference model
    do_clear();
    model_reset();
    for (int n = 0; n < 2400; n++) begin
      cpu_prob = (n < 1200) ? 45 : 12;
      clr = m_fail ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      ev  = ($urandom_range(0, 99) < 60);
      cv  = ($urandom_range(0, 99) < cpu_prob);
      r   = rand_rec();
      if (exp_q.size() != 0) begin
        a = RET_REC_T'(exp_q[0]);
        if ($urandom_range(0, 5) == 0) a = corrupt(a, $urandom_range(1, 12));
      end else begin
        a = rand_rec();
      end
      a.chk = CHECKS'(16'($urandom));
      clear_in     = clr;
      emu_valid_in = ev;
      emu_rec_in   = r;
      cpu_valid_in = cv;
      cpu_rec_in   = a;
      model_step(clr, ev, cv, r, a);
      cyc();
      check("rnd_mismatch", 32'(mismatch_out), 32'(m_mm));
      if (m_mm) begin
        check("rnd_flds", 32'(mismatch_flds_out), 32'(m_flds));
        check("rnd_itype", 32'(mismatch_itype_out), 32'(m_itype));
      end
      check("rnd_underflow", 32'(err_underflow_out), 32'(m_uf));
      check("rnd_timeout", 32'(err_timeout_out), 32'(m_to));
      check("rnd_fail", 32'(fail_out), 32'(m_fail));
      check("rnd_retire_cnt", retire_cnt_out, m_ret);
      check("rnd_mismatch_cnt", 32'(mismatch_cnt_out), 32'(m_mcnt));
      check("rnd_ready", 32'(emu_ready_out), 32'(exp_q.size() < DEPTH));
    end
    clear_in     = 1'b0;
    emu_valid_in = 1'b0;
    cpu_valid_in = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
